// File: rtl/exu_divider.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Divide-by-zero and signed overflow finish on a one-cycle fast path.
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif

module exu_divider #(
    parameter int WIDTH = `REG_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic [3:0]       op_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             valid_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    localparam logic [5:0] LAST_STEP = 6'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [5:0]       count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] divisor;
    logic             want_rem;
    logic             neg_quo;
    logic             neg_rem;
    logic [WIDTH-1:0] result;

    logic             dec_signed;
    logic             dec_rem;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             div_zero;
    logic             overflow;
    logic             accept;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    // DIVU is simply "neither signed nor remainder", so its one-hot bit is never read
    logic unused_divu;
    assign unused_divu = op_i[1];

    assign dec_signed = op_i[0] | op_i[2];
    assign dec_rem    = op_i[2] | op_i[3];
    assign sign_a     = dec_signed & dividend_i[WIDTH-1];
    assign sign_b     = dec_signed & divisor_i[WIDTH-1];
    assign mag_a      = sign_a ? -dividend_i : dividend_i;
    assign mag_b      = sign_b ? -divisor_i  : divisor_i;
    assign div_zero   = (divisor_i == '0);
    assign overflow   = dec_signed && (dividend_i == {1'b1, {(WIDTH-1){1'b0}}})
                        && (divisor_i == '1);
    assign accept     = (state == IDLE) && start_i;

    // The WIDTH+1-bit working remainder lets the trial subtraction expose its sign bit
    assign shifted = {rem, quo[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign q_bit   = ~trial[WIDTH];
    assign quo_fix = neg_quo ? -quo : quo;
    assign rem_fix = neg_rem ? -rem : rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_i) next_state = (div_zero || overflow) ? DONE : CALC;
            CALC:    if (count == LAST_STEP) next_state = FIXUP;
            FIXUP:   next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy_o   = (state != IDLE);
        valid_o  = (state == DONE);
        result_o = result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
            want_rem <= 1'b0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result   <= '0;
        end else if (accept) begin
            count    <= '0;
            rem      <= '0;
            quo      <= mag_a;
            divisor  <= mag_b;
            want_rem <= dec_rem;
            neg_quo  <= sign_a ^ sign_b;
            neg_rem  <= sign_a;
            if (div_zero) begin
                result <= dec_rem ? dividend_i : '1;
            end else if (overflow) begin
                result <= dec_rem ? '0 : dividend_i;
            end
        end else begin
            case (state)
                CALC: begin
                    rem   <= q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo   <= {quo[WIDTH-2:0], q_bit};
                    count <= count + 6'd1;
                end
                FIXUP: result <= want_rem ? rem_fix : quo_fix;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exu_divider.sv
// Self-checking bench for exu_divider: directed RV32M cases, timing, busy/reset
// behaviour, and randomized operations against an arithmetic reference model.
module tb_exu_divider;

    localparam logic [3:0] OP_DIV  = 4'b0001;
    localparam logic [3:0] OP_DIVU = 4'b0010;
    localparam logic [3:0] OP_REM  = 4'b0100;
    localparam logic [3:0] OP_REMU = 4'b1000;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [3:0]  op_i;
    logic [31:0] result_o;
    logic        busy_o;
    logic        valid_o;

    int compared   = 0;
    int mismatched = 0;

    exu_divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .op_i       (op_i),
        .result_o   (result_o),
        .busy_o     (busy_o),
        .valid_o    (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // RISC-V division semantics expressed with plain integer arithmetic
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        bit s = op[0] | op[2];
        bit r = op[2] | op[3];
        int sa = $signed(a);
        int sb = $signed(b);
        if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'd0 : 32'h8000_0000;
        if (s) return r ? 32'(sa % sb) : 32'(sa / sb);
        return r ? a % b : a / b;
    endfunction

    function automatic int ref_latency(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        bit s = op[0] | op[2];
        if (b == 32'd0) return 1;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation and returns the result seen with valid and the latency in cycles
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        tick();
        start_i    = 1'b0;
        op_i       = 4'($urandom);
        dividend_i = $urandom;
        divisor_i  = $urandom;
        lat = 1;
        while (!valid_o && lat < 40) begin
            tick();
            lat++;
        end
        res = result_o;
        tick();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        start_i    = 1'b0;
        op_i       = 4'd0;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        repeat (3) @(negedge clk);
        compared++;
        if (result_o !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_result: got %h expected 0", result_o);
        end
        compared++;
        if (busy_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_busy: got %b expected 0", busy_o);
        end
        compared++;
        if (valid_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_valid: got %b expected 0", valid_o);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [3:0]  ops  [11] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIVU, OP_DIV,
                                   OP_REMU, OP_REM, OP_DIV, OP_REM, OP_DIVU};
        logic [31:0] as   [11] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                   32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000,
                                   32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs   [11] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exps [11] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                   32'h7FFF_FFFC, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000,
                                   32'h8000_0000, 32'd0, 32'd0};
        int          lats [11] = '{34, 34, 34, 34, 34, 1, 1, 1, 1, 1, 34};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 11; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat);
            compared++;
            if (res !== exps[i]) begin
                mismatched++;
                $display("[TB] FAIL directed_result[%0d]: got %h expected %h", i, res, exps[i]);
            end
            compared++;
            if (lat != lats[i]) begin
                mismatched++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, lats[i]);
            end
        end
    endtask

    task automatic test_busy_profile();
        logic [31:0] prev = result_o;
        start_i    = 1'b1;
        op_i       = OP_DIVU;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        tick();
        start_i = 1'b0;
        for (int cyc = 1; cyc <= 35; cyc++) begin
            compared++;
            if (busy_o !== (cyc <= 34)) begin
                mismatched++;
                $display("[TB] FAIL profile_busy[N+%0d]: got %b expected %b", cyc, busy_o, cyc <= 34);
            end
            compared++;
            if (valid_o !== (cyc == 34)) begin
                mismatched++;
                $display("[TB] FAIL profile_valid[N+%0d]: got %b expected %b", cyc, valid_o, cyc == 34);
            end
            if (cyc <= 33) begin
                compared++;
                if (result_o !== prev) begin
                    mismatched++;
                    $display("[TB] FAIL profile_hold[N+%0d]: got %h expected %h", cyc, result_o, prev);
                end
            end else begin
                compared++;
                if (result_o !== 32'd14) begin
                    mismatched++;
                    $display("[TB] FAIL profile_result[N+%0d]: got %h expected %h", cyc, result_o, 32'd14);
                end
            end
            if (cyc < 35) tick();
        end
    endtask

    task automatic test_fast_timing();
        start_i    = 1'b1;
        op_i       = OP_DIV;
        dividend_i = 32'd5;
        divisor_i  = 32'd0;
        tick();
        start_i = 1'b0;
        compared++;
        if (busy_o !== 1'b1 || valid_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL fast_n1: got busy=%b valid=%b expected busy=1 valid=1", busy_o, valid_o);
        end
        compared++;
        if (result_o !== 32'hFFFF_FFFF) begin
            mismatched++;
            $display("[TB] FAIL fast_result: got %h expected ffffffff", result_o);
        end
        tick();
        compared++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL fast_n2: got busy=%b valid=%b expected busy=0 valid=0", busy_o, valid_o);
        end
    endtask

    task automatic test_busy_ignore();
        int extra_valid = 0;
        start_i    = 1'b1;
        op_i       = OP_DIVU;
        dividend_i = 32'd1000;
        divisor_i  = 32'd10;
        tick();
        for (int cyc = 1; cyc <= 70; cyc++) begin
            start_i = (cyc == 5) || (cyc == 34) || (cyc == 35);
            case (cyc)
                5:  begin op_i = OP_DIVU; dividend_i = 32'd999;  divisor_i = 32'd3; end
                34: begin op_i = OP_DIVU; dividend_i = 32'd7;    divisor_i = 32'd7; end
                35: begin op_i = OP_REMU; dividend_i = 32'd1000; divisor_i = 32'd7; end
                default: begin op_i = 4'($urandom); dividend_i = $urandom; divisor_i = $urandom; end
            endcase
            if (cyc == 34) begin
                compared++;
                if (valid_o !== 1'b1 || result_o !== 32'd100) begin
                    mismatched++;
                    $display("[TB] FAIL ignore_first: got valid=%b result=%h expected valid=1 result=%h",
                             valid_o, result_o, 32'd100);
                end
            end
            if (cyc == 35) begin
                compared++;
                if (busy_o !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL ignore_busy_n35: got %b expected 0", busy_o);
                end
            end
            if (cyc >= 36 && cyc <= 68 && valid_o) extra_valid++;
            if (cyc == 69) begin
                compared++;
                if (valid_o !== 1'b1 || result_o !== 32'd6) begin
                    mismatched++;
                    $display("[TB] FAIL ignore_second: got valid=%b result=%h expected valid=1 result=%h",
                             valid_o, result_o, 32'd6);
                end
            end
            tick();
        end
        start_i = 1'b0;
        compared++;
        if (extra_valid != 0) begin
            mismatched++;
            $display("[TB] FAIL ignore_stray_valid: got %0d pulses expected 0", extra_valid);
        end
    endtask

    task automatic test_reset_mid();
        int          stray = 0;
        logic [31:0] res;
        int          lat;
        start_i    = 1'b1;
        op_i       = OP_DIVU;
        dividend_i = 32'd100;
        divisor_i  = 32'd7;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (busy_o !== 1'b0 || valid_o !== 1'b0 || result_o !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL midreset_outputs: got busy=%b valid=%b result=%h expected all 0",
                     busy_o, valid_o, result_o);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 40; i++) begin
            if (valid_o || busy_o) stray++;
            tick();
        end
        compared++;
        if (stray != 0) begin
            mismatched++;
            $display("[TB] FAIL midreset_stray: got %0d active cycles expected 0", stray);
        end
        do_op(OP_DIVU, 32'd9, 32'd3, res, lat);
        compared++;
        if (res !== 32'd3 || lat != 34) begin
            mismatched++;
            $display("[TB] FAIL midreset_after: got result=%h lat=%0d expected result=3 lat=34", res, lat);
        end
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 200; i++) begin
            op = (i % 2 == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            do_op(op, a, b, res, lat);
            compared++;
            if (res !== ref_result(op, a, b)) begin
                mismatched++;
                $display("[TB] FAIL random_result[%0d] op=%b a=%h b=%h: got %h expected %h",
                         i, op, a, b, res, ref_result(op, a, b));
            end
            compared++;
            if (lat != ref_latency(op, a, b)) begin
                mismatched++;
                $display("[TB] FAIL random_latency[%0d] op=%b a=%h b=%h: got %0d expected %0d",
                         i, op, a, b, lat, ref_latency(op, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_busy_profile();
        test_fast_timing();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
